// File: rtl/im_loader.sv
// im_loader: packs an LSB-first byte stream into 32-bit instruction words and writes
// them into the instruction memory. Holds the core in reset until the image is complete.
module im_loader #(
   parameter int unsigned ROM_WIDTH     = 32,
   parameter int unsigned ROM_ADDR_BITS = 64
) (
   input  logic                 clk,
   input  logic                 rst_n,
   input  logic                 start,
   input  logic [15:0]          len_words,
   input  logic [7:0]           in_data,
   input  logic                 in_valid,
   output logic                 in_ready,
   output logic                 we,
   output logic [15:0]          waddr,
   output logic [ROM_WIDTH-1:0] wdata,
   output logic                 busy,
   output logic                 done,
   output logic                 err,
   output logic [ROM_WIDTH-1:0] checksum,
   output logic                 cpu_hold
);

   typedef enum logic [1:0] {StIdle, StLoad, StWrite, StDone} state_e;

   state_e               state_q, state_d;
   logic [1:0]           byte_cnt_q, byte_cnt_d;
   logic [15:0]          word_cnt_q, word_cnt_d;
   logic [15:0]          len_q, len_d;
   logic [23:0]          part_q, part_d;
   logic                 we_q, we_d;
   logic [15:0]          waddr_q, waddr_d;
   logic [ROM_WIDTH-1:0] wdata_q, wdata_d;
   logic                 busy_q, busy_d;
   logic                 done_q, done_d;
   logic                 err_q, err_d;
   logic [ROM_WIDTH-1:0] checksum_q, checksum_d;
   logic                 cpu_hold_q, cpu_hold_d;
   logic                 len_bad;
   logic [ROM_WIDTH-1:0] word_full;

   // Zero or longer than the IM: reject, so word_cnt can never exceed the array.
   assign len_bad   = (len_words == 16'd0) || ({16'd0, len_words} > ROM_ADDR_BITS);
   assign word_full = {in_data, part_q};

   // Next-state and registered-output computation
   always_comb begin
      state_d    = state_q;
      byte_cnt_d = byte_cnt_q;
      word_cnt_d = word_cnt_q;
      len_d      = len_q;
      part_d     = part_q;
      we_d       = 1'b0;
      waddr_d    = waddr_q;
      wdata_d    = wdata_q;
      done_d     = done_q;
      err_d      = 1'b0;
      checksum_d = checksum_q;
      cpu_hold_d = cpu_hold_q;

      unique case (state_q)
         StIdle, StDone: begin
            if (start) begin
               if (len_bad) begin
                  err_d = 1'b1;
               end else begin
                  state_d    = StLoad;
                  len_d      = len_words;
                  word_cnt_d = 16'd0;
                  byte_cnt_d = 2'd0;
                  part_d     = 24'd0;
                  checksum_d = '0;
                  done_d     = 1'b0;
                  cpu_hold_d = 1'b1;
               end
            end
         end
         StLoad: begin
            if (in_valid) begin
               byte_cnt_d = byte_cnt_q + 2'd1;
               unique case (byte_cnt_q)
                  2'd0: part_d[7:0]   = in_data;
                  2'd1: part_d[15:8]  = in_data;
                  2'd2: part_d[23:16] = in_data;
                  default: begin
                     // 4th byte completes the word; issue the write next cycle.
                     state_d    = StWrite;
                     we_d       = 1'b1;
                     waddr_d    = {word_cnt_q[13:0], 2'b00};
                     wdata_d    = word_full;
                     checksum_d = checksum_q ^ word_full;
                  end
               endcase
            end
         end
         StWrite: begin
            if (word_cnt_q + 16'd1 == len_q) begin
               state_d    = StDone;
               done_d     = 1'b1;
               cpu_hold_d = 1'b0;
            end else begin
               word_cnt_d = word_cnt_q + 16'd1;
               state_d    = StLoad;
            end
         end
         default: state_d = StIdle;
      endcase

      busy_d = (state_d == StLoad) || (state_d == StWrite);
   end

   // State and output registers; async reset discards any partial word
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q    <= StIdle;
         byte_cnt_q <= 2'd0;
         word_cnt_q <= 16'd0;
         len_q      <= 16'd0;
         part_q     <= 24'd0;
         we_q       <= 1'b0;
         waddr_q    <= 16'd0;
         wdata_q    <= '0;
         busy_q     <= 1'b0;
         done_q     <= 1'b0;
         err_q      <= 1'b0;
         checksum_q <= '0;
         cpu_hold_q <= 1'b1;
      end else begin
         state_q    <= state_d;
         byte_cnt_q <= byte_cnt_d;
         word_cnt_q <= word_cnt_d;
         len_q      <= len_d;
         part_q     <= part_d;
         we_q       <= we_d;
         waddr_q    <= waddr_d;
         wdata_q    <= wdata_d;
         busy_q     <= busy_d;
         done_q     <= done_d;
         err_q      <= err_d;
         checksum_q <= checksum_d;
         cpu_hold_q <= cpu_hold_d;
      end
   end

   assign in_ready = (state_q == StLoad);
   assign we       = we_q;
   assign waddr    = waddr_q;
   assign wdata    = wdata_q;
   assign busy     = busy_q;
   assign done     = done_q;
   assign err      = err_q;
   assign checksum = checksum_q;
   assign cpu_hold = cpu_hold_q;

endmodule

// File: tb/tb_im_loader.sv
// Directed bench for im_loader: directed loads, stream gaps, length rejects, async reset.
module tb_im_loader;

   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic        start = 1'b0;
   logic [15:0] len_words = 16'd0;
   logic [7:0]  in_data = 8'd0;
   logic        in_valid = 1'b0;
   logic        in_ready, we, busy, done, err, cpu_hold;
   logic [15:0] waddr;
   logic [31:0] wdata, checksum;

   int n_pass = 0;
   int n_total = 0;

   logic [15:0] wa[$];
   logic [31:0] wd[$];
   logic [31:0] prog [0:8];

   im_loader dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .start     (start),
      .len_words (len_words),
      .in_data   (in_data),
      .in_valid  (in_valid),
      .in_ready  (in_ready),
      .we        (we),
      .waddr     (waddr),
      .wdata     (wdata),
      .busy      (busy),
      .done      (done),
      .err       (err),
      .checksum  (checksum),
      .cpu_hold  (cpu_hold)
   );

   always #5 clk = ~clk;

   // Log every write pulse away from the active edge
   always @(negedge clk) begin
      if (we === 1'b1) begin
         wa.push_back(waddr);
         wd.push_back(wdata);
      end
   end

   initial begin
      #500000;
      $display("FAIL watchdog: simulation did not finish, required finish before 500us");
      $fatal(1, "watchdog");
   end

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_total++;
      assert (obs === exp) n_pass++;
      else $error("FAIL %s: observed %h required %h", tag, obs, exp);
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic do_start(input logic [15:0] len);
      start = 1'b1;
      len_words = len;
      tick();
      start = 1'b0;
   endtask

   task automatic send_byte(input logic [7:0] b, input int idle);
      int n;
      in_valid = 1'b0;
      repeat (idle) tick();
      in_valid = 1'b1;
      in_data = b;
      n = 0;
      while (in_ready !== 1'b1 && n < 50) begin
         tick();
         n++;
      end
      if (n >= 50) chk("in_ready_wait", {31'd0, in_ready}, 32'd1);
      tick();
      in_valid = 1'b0;
   endtask

   task automatic send_word(input logic [31:0] w, input bit gaps);
      for (int i = 0; i < 4; i++) begin
         int idle;
         idle = 0;
         if (gaps) begin
            while ($urandom_range(0, 9) < 3 && idle < 5) idle++;
         end
         send_byte(w[8*i +: 8], idle);
      end
   endtask

   task automatic wait_done();
      int n;
      n = 0;
      while (done !== 1'b1 && n < 30) begin
         tick();
         n++;
      end
      chk("done_set", {31'd0, done}, 32'd1);
   endtask

   // Load prog[0..len-1] and compare the full write sequence and checksum
   task automatic run_prog(input string tag, input int len, input bit gaps);
      logic [31:0] x;
      wa.delete();
      wd.delete();
      do_start(16'(len));
      chk({tag, "_busy"}, {31'd0, busy}, 32'd1);
      chk({tag, "_hold"}, {31'd0, cpu_hold}, 32'd1);
      for (int i = 0; i < len; i++) send_word(prog[i], gaps);
      wait_done();
      chk({tag, "_nwrites"}, wa.size(), len);
      x = 32'd0;
      for (int i = 0; i < len && i < wa.size(); i++) begin
         chk({tag, "_waddr"}, {16'd0, wa[i]}, 32'(i * 4));
         chk({tag, "_wdata"}, wd[i], prog[i]);
         x = x ^ prog[i];
      end
      chk({tag, "_checksum"}, checksum, x);
      chk({tag, "_cpu_hold"}, {31'd0, cpu_hold}, 32'd0);
      chk({tag, "_busy_end"}, {31'd0, busy}, 32'd0);
   endtask

   task automatic chk_reset(input string tag);
      chk({tag, "_in_ready"}, {31'd0, in_ready}, 32'd0);
      chk({tag, "_we"}, {31'd0, we}, 32'd0);
      chk({tag, "_waddr"}, {16'd0, waddr}, 32'd0);
      chk({tag, "_wdata"}, wdata, 32'd0);
      chk({tag, "_busy"}, {31'd0, busy}, 32'd0);
      chk({tag, "_done"}, {31'd0, done}, 32'd0);
      chk({tag, "_err"}, {31'd0, err}, 32'd0);
      chk({tag, "_checksum"}, checksum, 32'd0);
      chk({tag, "_cpu_hold"}, {31'd0, cpu_hold}, 32'd1);
   endtask

   initial begin
      prog[0] = 32'h00300413;  // addi s0,x0,3
      prog[1] = 32'h00300493;  // addi s1,x0,3
      prog[2] = 32'h00940463;  // beq  s0,s1,+8
      prog[3] = 32'h00100513;  // addi a0,x0,1
      prog[4] = 32'h00200593;  // addi a1,x0,2
      prog[5] = 32'h00b50633;  // add  a2,a0,a1
      prog[6] = 32'h008000ef;  // jal  ra,+8
      prog[7] = 32'h00000013;  // nop
      prog[8] = 32'hff5ff06f;  // jal  x0,-12

      // Reset state
      #12;
      chk_reset("rst");
      @(negedge clk);
      rst_n = 1'b1;
      tick();

      // Bad lengths from IDLE: 1-cycle err, nothing else moves
      do_start(16'd0);
      chk("len0_err", {31'd0, err}, 32'd1);
      chk("len0_busy", {31'd0, busy}, 32'd0);
      chk("len0_hold", {31'd0, cpu_hold}, 32'd1);
      tick();
      chk("len0_err_pulse", {31'd0, err}, 32'd0);
      do_start(16'd65);
      chk("len65_err", {31'd0, err}, 32'd1);
      chk("len65_in_ready", {31'd0, in_ready}, 32'd0);
      tick();
      chk("len65_err_pulse", {31'd0, err}, 32'd0);
      chk("len65_hold", {31'd0, cpu_hold}, 32'd1);
      chk("bad_len_nwrites", wa.size(), 0);

      // Single word
      run_prog("t1", 1, 1'b0);
      chk("t1_wdata_const", wdata, 32'h00300413);
      chk("t1_checksum_const", checksum, 32'h00300413);

      // Bad start in DONE: err, done stays
      do_start(16'd65);
      chk("done_bad_err", {31'd0, err}, 32'd1);
      chk("done_bad_done", {31'd0, done}, 32'd1);
      chk("done_bad_hold", {31'd0, cpu_hold}, 32'd0);

      // Nine-word program, back-to-back then with random gaps
      run_prog("t2", 9, 1'b0);
      chk("t2_last_wdata", wdata, 32'hff5ff06f);
      chk("t2_last_waddr", {16'd0, waddr}, 32'd32);
      run_prog("t3", 9, 1'b1);

      // Start during LOAD is ignored
      wa.delete();
      wd.delete();
      do_start(16'd2);
      send_byte(prog[0][7:0], 0);
      send_byte(prog[0][15:8], 0);
      do_start(16'd1);
      chk("t6_ign_err", {31'd0, err}, 32'd0);
      chk("t6_ign_busy", {31'd0, busy}, 32'd1);
      send_byte(prog[0][23:16], 0);
      send_byte(prog[0][31:24], 0);
      send_word(prog[1], 1'b0);
      wait_done();
      chk("t6_ign_nwrites", wa.size(), 2);
      if (wa.size() == 2) begin
         chk("t6_ign_wdata1", wd[1], prog[1]);
         chk("t6_ign_waddr1", {16'd0, wa[1]}, 32'd4);
      end

      // Restart from DONE
      wa.delete();
      wd.delete();
      do_start(16'd2);
      chk("t6_re_done", {31'd0, done}, 32'd0);
      chk("t6_re_hold", {31'd0, cpu_hold}, 32'd1);
      chk("t6_re_checksum", checksum, 32'd0);
      send_word(prog[2], 1'b0);
      send_word(prog[3], 1'b0);
      wait_done();
      chk("t6_re_nwrites", wa.size(), 2);
      if (wa.size() == 2) begin
         chk("t6_re_waddr0", {16'd0, wa[0]}, 32'd0);
         chk("t6_re_wdata0", wd[0], 32'h00940463);
         chk("t6_re_waddr1", {16'd0, wa[1]}, 32'd4);
         chk("t6_re_wdata1", wd[1], 32'h00100513);
      end
      chk("t6_re_checksum_end", checksum, 32'h00940463 ^ 32'h00100513);

      // Async reset mid-word discards the partial word
      wa.delete();
      wd.delete();
      do_start(16'd1);
      send_byte(8'haa, 0);
      send_byte(8'hbb, 0);
      #2;
      rst_n = 1'b0;
      #1;
      chk_reset("t5");
      repeat (2) @(posedge clk);
      @(negedge clk);
      rst_n = 1'b1;
      tick();
      chk("t5_nwrites", wa.size(), 0);
      run_prog("t5_reload", 1, 1'b0);

      $display("%0d/%0d checks passed", n_pass, n_total);
      $finish;
   end

endmodule
